// File: rtl/vram_rect_fill.sv
// -----------------------------------------------------------------------------
// vram_rect_fill
// Solid-colour rectangle fill engine driving the VRAM word write port.
// One command describes a rectangle in cell coordinates (origin, size, colour).
// The engine clips the rectangle to the screen. It then writes every covered
// 16-bit word in row-major order, one word per accepted write. Partial words at
// the row edges are handled with byte masks, so no read-modify-write is needed.
// Word layout: [15:8] holds the even cell, [7:0] holds the odd cell, and the
// colour sits in the low six bits of each byte.
//
// Ports
//   clk, reset           clock, asynchronous active-high reset
//   cmd_valid/cmd_ready  command handshake (ready only while idle)
//   cmd_x0, cmd_y0       first cell column / row
//   cmd_w, cmd_h         width / height in cells
//   cmd_color            RRGGBB fill colour
//   busy                 command in progress
//   done                 one-cycle pulse when a command completes
//   vram_waddr/wdata/    VRAM write request (address, data, byte enables,
//   vram_wmask/vram_we   write strobe)
//   vram_wready          VRAM accepts the presented write this cycle
// -----------------------------------------------------------------------------
module vram_rect_fill #(
    parameter int COLS          = 160,
    parameter int ROWS          = 60,
    parameter int WORDS_PER_ROW = 80,
    parameter int BASE_ADDR     = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_x0,
    input  logic [5:0]  cmd_y0,
    input  logic [7:0]  cmd_w,
    input  logic [5:0]  cmd_h,
    input  logic [5:0]  cmd_color,
    output logic        busy,
    output logic        done,
    output logic [13:0] vram_waddr,
    output logic [15:0] vram_wdata,
    output logic [1:0]  vram_wmask,
    output logic        vram_we,
    input  logic        vram_wready
);

    localparam logic [8:0]  COLS_W = 9'(COLS);
    localparam logic [8:0]  ROWS_W = 9'(ROWS);
    localparam logic [13:0] WPR_W  = 14'(WORDS_PER_ROW);
    localparam logic [13:0] BASE_W = 14'(BASE_ADDR);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        FILL  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Row offset WORDS_PER_ROW*y built from shifted constants (shift-add only).
    function automatic logic [13:0] row_offset(input logic [5:0] y);
        logic [13:0] acc;
        acc = 14'd0;
        for (int i = 0; i < 6; i++) begin
            if (y[i]) begin
                acc = acc + (WPR_W << i);
            end else begin
                acc = acc;
            end
        end
        return acc;
    endfunction

    // Byte enables for word wx: the first word loses its even byte when x0 is
    // odd, the last word loses its odd byte when xe-1 is even (xe odd).
    function automatic logic [1:0] mask_for(input logic [6:0] wx,
                                            input logic [6:0] wfirst,
                                            input logic [6:0] wlast,
                                            input logic       x0_odd,
                                            input logic       xe_odd);
        return {~((wx == wfirst) && x0_odd), ~((wx == wlast) && xe_odd)};
    endfunction

    state_t      state_r, state_s;
    logic [7:0]  x0_r, x0_s;
    logic [5:0]  y0_r, y0_s;
    logic [7:0]  w_r, w_s;
    logic [5:0]  h_r, h_s;
    logic [5:0]  color_r, color_s;
    logic [6:0]  wfirst_r, wfirst_s;
    logic [6:0]  wlast_r, wlast_s;
    logic        x0_odd_r, x0_odd_s;
    logic        xe_odd_r, xe_odd_s;
    logic [5:0]  y_r, y_s;
    logic [5:0]  ylast_r, ylast_s;
    logic [6:0]  wx_r, wx_s;
    logic [13:0] row_base_r, row_base_s;
    logic        cmd_ready_r, cmd_ready_s;
    logic        busy_r, busy_s;
    logic        done_r, done_s;
    logic [13:0] waddr_r, waddr_s;
    logic [15:0] wdata_r, wdata_s;
    logic [1:0]  wmask_r, wmask_s;
    logic        we_r, we_s;

    // Clipped extents, derived from the registered command during SETUP.
    logic [8:0]  xsum_s, ysum_s, xe_s, ye_s;
    logic [6:0]  setup_wlast_s;
    logic [5:0]  setup_ylast_s;
    logic [13:0] setup_row_s;
    logic        reject_s;
    logic [6:0]  wx_inc_s;
    logic [13:0] next_row_s;

    // Extent clipping, reject decision and walk increments.
    always_comb begin
        xsum_s        = {1'b0, x0_r} + {1'b0, w_r};
        ysum_s        = {3'b000, y0_r} + {3'b000, h_r};
        xe_s          = (xsum_s > COLS_W) ? COLS_W : xsum_s;
        ye_s          = (ysum_s > ROWS_W) ? ROWS_W : ysum_s;
        setup_wlast_s = 7'((xe_s - 9'd1) >> 1);
        setup_ylast_s = 6'(ye_s - 9'd1);
        setup_row_s   = BASE_W + row_offset(y0_r);
        reject_s      = (w_r == 8'd0) || (h_r == 6'd0) ||
                        ({1'b0, x0_r} >= COLS_W) || ({3'b000, y0_r} >= ROWS_W);
        wx_inc_s      = wx_r + 7'd1;
        next_row_s    = row_base_r + WPR_W;
    end

    // Next-state and next-output logic for the fill FSM.
    always_comb begin
        state_s     = state_r;
        x0_s        = x0_r;
        y0_s        = y0_r;
        w_s         = w_r;
        h_s         = h_r;
        color_s     = color_r;
        wfirst_s    = wfirst_r;
        wlast_s     = wlast_r;
        x0_odd_s    = x0_odd_r;
        xe_odd_s    = xe_odd_r;
        y_s         = y_r;
        ylast_s     = ylast_r;
        wx_s        = wx_r;
        row_base_s  = row_base_r;
        cmd_ready_s = cmd_ready_r;
        busy_s      = busy_r;
        done_s      = 1'b0;
        waddr_s     = waddr_r;
        wdata_s     = wdata_r;
        wmask_s     = wmask_r;
        we_s        = we_r;

        case (state_r)
            IDLE: begin
                if (cmd_valid && cmd_ready_r) begin
                    x0_s        = cmd_x0;
                    y0_s        = cmd_y0;
                    w_s         = cmd_w;
                    h_s         = cmd_h;
                    color_s     = cmd_color;
                    state_s     = SETUP;
                    cmd_ready_s = 1'b0;
                    busy_s      = 1'b1;
                end else begin
                    cmd_ready_s = 1'b1;
                    busy_s      = 1'b0;
                end
            end
            SETUP: begin
                wfirst_s = x0_r[7:1];
                wlast_s  = setup_wlast_s;
                x0_odd_s = x0_r[0];
                xe_odd_s = xe_s[0];
                ylast_s  = setup_ylast_s;
                if (reject_s) begin
                    state_s = DONE;
                    done_s  = 1'b1;
                end else begin
                    // Present the first word straight away so we rises one
                    // cycle after SETUP.
                    state_s    = FILL;
                    y_s        = y0_r;
                    wx_s       = x0_r[7:1];
                    row_base_s = setup_row_s;
                    waddr_s    = setup_row_s + {7'd0, x0_r[7:1]};
                    wdata_s    = {2'b00, color_r, 2'b00, color_r};
                    wmask_s    = mask_for(x0_r[7:1], x0_r[7:1], setup_wlast_s,
                                          x0_r[0], xe_s[0]);
                    we_s       = 1'b1;
                end
            end
            FILL: begin
                // Advance only on a completed write; otherwise hold everything.
                if (we_r && vram_wready) begin
                    if (wx_r == wlast_r) begin
                        if (y_r == ylast_r) begin
                            we_s    = 1'b0;
                            state_s = DONE;
                            done_s  = 1'b1;
                        end else begin
                            y_s        = y_r + 6'd1;
                            row_base_s = next_row_s;
                            wx_s       = wfirst_r;
                            waddr_s    = next_row_s + {7'd0, wfirst_r};
                            wmask_s    = mask_for(wfirst_r, wfirst_r, wlast_r,
                                                  x0_odd_r, xe_odd_r);
                        end
                    end else begin
                        wx_s    = wx_inc_s;
                        waddr_s = row_base_r + {7'd0, wx_inc_s};
                        wmask_s = mask_for(wx_inc_s, wfirst_r, wlast_r,
                                           x0_odd_r, xe_odd_r);
                    end
                end else begin
                    we_s = we_r;
                end
            end
            DONE: begin
                state_s     = IDLE;
                busy_s      = 1'b0;
                cmd_ready_s = 1'b1;
            end
            default: begin
                state_s     = IDLE;
                we_s        = 1'b0;
                busy_s      = 1'b0;
                cmd_ready_s = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any command immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            x0_r        <= 8'd0;
            y0_r        <= 6'd0;
            w_r         <= 8'd0;
            h_r         <= 6'd0;
            color_r     <= 6'd0;
            wfirst_r    <= 7'd0;
            wlast_r     <= 7'd0;
            x0_odd_r    <= 1'b0;
            xe_odd_r    <= 1'b0;
            y_r         <= 6'd0;
            ylast_r     <= 6'd0;
            wx_r        <= 7'd0;
            row_base_r  <= 14'd0;
            cmd_ready_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            waddr_r     <= 14'd0;
            wdata_r     <= 16'd0;
            wmask_r     <= 2'd0;
            we_r        <= 1'b0;
        end else begin
            state_r     <= state_s;
            x0_r        <= x0_s;
            y0_r        <= y0_s;
            w_r         <= w_s;
            h_r         <= h_s;
            color_r     <= color_s;
            wfirst_r    <= wfirst_s;
            wlast_r     <= wlast_s;
            x0_odd_r    <= x0_odd_s;
            xe_odd_r    <= xe_odd_s;
            y_r         <= y_s;
            ylast_r     <= ylast_s;
            wx_r        <= wx_s;
            row_base_r  <= row_base_s;
            cmd_ready_r <= cmd_ready_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            waddr_r     <= waddr_s;
            wdata_r     <= wdata_s;
            wmask_r     <= wmask_s;
            we_r        <= we_s;
        end
    end

    assign cmd_ready  = cmd_ready_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign vram_waddr = waddr_r;
    assign vram_wdata = wdata_r;
    assign vram_wmask = wmask_r;
    assign vram_we    = we_r;

endmodule

// File: tb/tb_vram_rect_fill.sv
// -----------------------------------------------------------------------------
// tb_vram_rect_fill
// Scoreboard bench for vram_rect_fill. Each command pushes its hand-computed
// write list into exp_q. A monitor on the falling edge compares every presented
// write with the queue head. The head is popped only when the write completes,
// so a stalled write must keep matching the same entry.
// -----------------------------------------------------------------------------
module tb_vram_rect_fill;

    typedef struct packed {
        logic [13:0] a;
        logic [15:0] d;
        logic [1:0]  m;
    } wr_t;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_x0;
    logic [5:0]  cmd_y0;
    logic [7:0]  cmd_w;
    logic [5:0]  cmd_h;
    logic [5:0]  cmd_color;
    logic        busy;
    logic        done;
    logic [13:0] vram_waddr;
    logic [15:0] vram_wdata;
    logic [1:0]  vram_wmask;
    logic        vram_we;
    logic        vram_wready;

    wr_t exp_q[$];
    int  tests     = 0;
    int  fails     = 0;
    int  done_cnt  = 0;
    int  wr_cnt    = 0;
    bit  stall_mode = 1'b0;

    vram_rect_fill dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_x0     (cmd_x0),
        .cmd_y0     (cmd_y0),
        .cmd_w      (cmd_w),
        .cmd_h      (cmd_h),
        .cmd_color  (cmd_color),
        .busy       (busy),
        .done       (done),
        .vram_waddr (vram_waddr),
        .vram_wdata (vram_wdata),
        .vram_wmask (vram_wmask),
        .vram_we    (vram_we),
        .vram_wready(vram_wready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input int a, input logic [15:0] d, input logic [1:0] m);
        wr_t e;
        e.a = 14'(a);
        e.d = d;
        e.m = m;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor: compare every presented write, pop on completion.
    always @(negedge clk) begin
        if (!reset) begin
            if (done) done_cnt++;
            if (vram_we) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", {18'd0, vram_waddr}, 32'd0);
                end else begin
                    chk("write", {vram_waddr, vram_wdata, vram_wmask}, exp_q[0]);
                    if (vram_wready) begin
                        void'(exp_q.pop_front());
                        wr_cnt++;
                    end
                end
            end
        end
    end

    // VRAM ready: always ready, or pseudo-random stalls.
    initial begin
        vram_wready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            vram_wready = stall_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    // Wait for cmd_ready, then present the command for exactly one accept edge.
    // Returns #1 after the accept edge.
    task automatic issue(input logic [7:0] x0, input logic [5:0] y0,
                         input logic [7:0] w, input logic [5:0] h, input logic [5:0] c);
        int n;
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("ready_wait", {31'd0, cmd_ready}, 32'd1);
        cmd_x0 = x0; cmd_y0 = y0; cmd_w = w; cmd_h = h; cmd_color = c;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    // Wait (bounded) for the done pulse, then check the queue drained and
    // that the engine is back in IDLE one cycle later.
    task automatic wait_done(input string name, input int budget);
        int start;
        int n;
        start = done_cnt;
        n = 0;
        while (done_cnt == start && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({name, "_done_count"}, done_cnt - start, 1);
        chk({name, "_queue_left"}, exp_q.size(), 0);
        chk({name, "_idle"}, {29'd0, cmd_ready, busy, done}, {29'd0, 3'b100});
        exp_q.delete();
    endtask

    initial begin
        int base_wr;
        int base_done;
        reset = 1'b1;
        cmd_valid = 1'b0;
        cmd_x0 = 8'd0; cmd_y0 = 6'd0; cmd_w = 8'd0; cmd_h = 6'd0; cmd_color = 6'd0;
        #1;
        chk("reset_ctrl", {28'd0, cmd_ready, busy, done, vram_we}, 32'd0);
        chk("reset_data", {vram_waddr, vram_wdata, vram_wmask}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_reset", {31'd0, cmd_ready}, 32'd1);

        // 1: full clear
        for (int a = 1; a <= 4800; a++) push(a, 16'h0000, 2'b11);
        base_wr = wr_cnt;
        issue(8'd0, 6'd0, 8'd160, 6'd60, 6'h00);
        wait_done("full_clear", 6000);
        chk("full_clear_writes", wr_cnt - base_wr, 4800);

        // 2: single odd cell, we timing
        push(162, 16'h2A2A, 2'b01);
        issue(8'd3, 6'd2, 8'd1, 6'd1, 6'h2A);
        chk("setup_cycle", {29'd0, vram_we, busy, cmd_ready}, {29'd0, 3'b010});
        @(posedge clk);
        #1;
        chk("we_at_n2", {31'd0, vram_we}, 32'd1);
        wait_done("odd_cell", 50);

        // 3: clipped rectangle; a command offered while busy must be ignored
        for (int a = 4716; a <= 4720; a++) push(a, 16'h1515, 2'b11);
        for (int a = 4796; a <= 4800; a++) push(a, 16'h1515, 2'b11);
        base_wr = wr_cnt;
        issue(8'd150, 6'd58, 8'd20, 6'd10, 6'h15);
        cmd_x0 = 8'd0; cmd_y0 = 6'd0; cmd_w = 8'd2; cmd_h = 6'd1; cmd_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        wait_done("clip", 100);
        chk("clip_writes", wr_cnt - base_wr, 10);

        // 4: even-aligned odd width
        push(3, 16'h3F3F, 2'b11);
        push(4, 16'h3F3F, 2'b10);
        push(83, 16'h3F3F, 2'b11);
        push(84, 16'h3F3F, 2'b10);
        issue(8'd4, 6'd0, 8'd3, 6'd2, 6'h3F);
        wait_done("even_odd_w", 50);

        // 5: same with random stalls
        stall_mode = 1'b1;
        push(3, 16'h0909, 2'b11);
        push(4, 16'h0909, 2'b10);
        push(83, 16'h0909, 2'b11);
        push(84, 16'h0909, 2'b10);
        base_wr = wr_cnt;
        issue(8'd4, 6'd0, 8'd3, 6'd2, 6'h09);
        wait_done("stalls", 300);
        chk("stall_writes", wr_cnt - base_wr, 4);
        stall_mode = 1'b0;
        @(posedge clk);
        #1;

        // 6a: reject (w=0): done two cycles after accept, no writes
        base_wr = wr_cnt;
        issue(8'd10, 6'd10, 8'd0, 6'd5, 6'h01);
        chk("reject_no_done_yet", {31'd0, done}, 32'd0);
        @(posedge clk);
        #1;
        chk("reject_done", {30'd0, done, vram_we}, {30'd0, 2'b10});
        wait_done("reject", 10);
        chk("reject_writes", wr_cnt - base_wr, 0);

        // 6b: reset during a full fill, then a fresh command
        for (int a = 1; a <= 4800; a++) push(a, 16'h0707, 2'b11);
        base_done = done_cnt;
        issue(8'd0, 6'd0, 8'd160, 6'd60, 6'h07);
        repeat (40) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("abort_async", {29'd0, vram_we, busy, done}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        exp_q.delete();
        reset = 1'b0;
        chk("abort_no_done", done_cnt - base_done, 0);
        push(3, 16'h2222, 2'b11);
        push(4, 16'h2222, 2'b10);
        push(83, 16'h2222, 2'b11);
        push(84, 16'h2222, 2'b10);
        issue(8'd4, 6'd0, 8'd3, 6'd2, 6'h22);
        wait_done("after_reset", 50);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
